// File: rtl/uart_sram_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sram_cmd_ctrl
//  Purpose  : Byte-level command sequencer between a UART byte stream and one
//             shared SRAM port. It parses host frames, performs single-word
//             reads and writes, and streams the responses back over UART TX.
//               'W' A D0 D1 D2 D3  -> write, reply 'K'
//               'R' A              -> read,  reply D0 D1 D2 D3
//               other opcode       -> reply '?'
//  Config   : UART_CSUM_EN - when defined, each frame carries a trailing XOR
//             checksum byte. A mismatch replies '!' and makes no memory access.
//  Ports    : wb_clk_i/wb_rst_i  clock, async active-high reset
//             rx_data/rx_valid   received byte stream
//             tx_data/tx_valid/tx_ready  transmit byte handshake
//             mem_req/mem_we/mem_addr/mem_wdata/mem_gnt/mem_rdata  SRAM port
//             busy               high whenever not IDLE
//             err_cnt            saturating protocol-error counter
//  Revision : 1.0  initial release
// ============================================================================
module uart_sram_cmd_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 43400,
  parameter int ERR_W   = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int          TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  C_OP_WR  = 8'h57;
  localparam logic [7:0]  C_OP_RD  = 8'h52;
  localparam logic [7:0]  C_ACK    = 8'h4B;
  localparam logic [7:0]  C_BADOP  = 8'h3F;
`ifdef UART_CSUM_EN
  localparam logic [7:0]  C_BADSUM = 8'h21;
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_SEND     = 3'd5
`ifdef UART_CSUM_EN
    ,ST_GET_CSUM = 3'd6
`endif
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_is_write, w_is_write_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [31:0]         r_wdata, w_wdata_nxt;
  logic [1:0]          r_byte_cnt, w_byte_cnt_nxt;
  logic [31:0]         r_tx_buf, w_tx_buf_nxt;
  logic [2:0]          r_tx_len, w_tx_len_nxt;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
  logic [ERR_W-1:0]    r_err, w_err_nxt;
  logic                w_err_evt;
  logic                w_rx_state;
  logic                w_tmo_hit;
  logic [ADDR_W-1:0]   w_addr_byte;
  state_t              w_after_payload;
`ifdef UART_CSUM_EN
  logic [7:0]          r_csum, w_csum_nxt;
`endif

  // Address byte is zero-extended or truncated to the SRAM address width.
  assign w_addr_byte = ADDR_W'(rx_data);

`ifdef UART_CSUM_EN
  assign w_after_payload = ST_GET_CSUM;
`else
  assign w_after_payload = ST_MEM_REQ;
`endif

`ifdef UART_CSUM_EN
  assign w_rx_state = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA) ||
                      (r_state == ST_GET_CSUM);
`else
  assign w_rx_state = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
`endif

  // Timeout fires on the TIMEOUT-th consecutive silent cycle of a receive state.
  assign w_tmo_hit = w_rx_state && !rx_valid && (r_tmo == TMO_W'(TIMEOUT - 1));

  assign tx_valid  = (r_state == ST_SEND);
  assign tx_data   = r_tx_buf[7:0];
  assign mem_req   = (r_state == ST_MEM_REQ);
  assign mem_we    = (r_state == ST_MEM_REQ) && r_is_write;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != ST_IDLE);
  assign err_cnt   = r_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_byte_cnt <= '0;
      r_tx_buf   <= '0;
      r_tx_len   <= '0;
      r_tmo      <= '0;
      r_err      <= '0;
`ifdef UART_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_is_write <= w_is_write_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_tx_buf   <= w_tx_buf_nxt;
      r_tx_len   <= w_tx_len_nxt;
      r_tmo      <= w_tmo_nxt;
      r_err      <= w_err_nxt;
`ifdef UART_CSUM_EN
      r_csum     <= w_csum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_is_write_nxt = r_is_write;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_byte_cnt_nxt = r_byte_cnt;
    w_tx_buf_nxt   = r_tx_buf;
    w_tx_len_nxt   = r_tx_len;
    w_tmo_nxt      = '0;
    w_err_evt      = 1'b0;
`ifdef UART_CSUM_EN
    w_csum_nxt     = r_csum;
`endif

    if (w_rx_state && !rx_valid && !w_tmo_hit) begin
      w_tmo_nxt = r_tmo + 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
`ifdef UART_CSUM_EN
          w_csum_nxt = rx_data;
`endif
          if (rx_data == C_OP_WR) begin
            w_is_write_nxt = 1'b1;
            w_state_nxt    = ST_GET_ADDR;
          end else if (rx_data == C_OP_RD) begin
            w_is_write_nxt = 1'b0;
            w_state_nxt    = ST_GET_ADDR;
          end else begin
            w_tx_buf_nxt = {24'h0, C_BADOP};
            w_tx_len_nxt = 3'd1;
            w_err_evt    = 1'b1;
            w_state_nxt  = ST_SEND;
          end
        end
      end

      ST_GET_ADDR: begin
        if (rx_valid) begin
          w_addr_nxt     = w_addr_byte;
          w_byte_cnt_nxt = 2'd0;
`ifdef UART_CSUM_EN
          w_csum_nxt     = r_csum ^ rx_data;
`endif
          w_state_nxt    = r_is_write ? ST_GET_DATA : w_after_payload;
        end else if (w_tmo_hit) begin
          w_err_evt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_GET_DATA: begin
        if (rx_valid) begin
          // Shift in from the top so D0 ends up in bits [7:0] after four bytes.
          w_wdata_nxt    = {rx_data, r_wdata[31:8]};
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
`ifdef UART_CSUM_EN
          w_csum_nxt     = r_csum ^ rx_data;
`endif
          if (r_byte_cnt == 2'd3) begin
            w_state_nxt = w_after_payload;
          end
        end else if (w_tmo_hit) begin
          w_err_evt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

`ifdef UART_CSUM_EN
      ST_GET_CSUM: begin
        if (rx_valid) begin
          if (rx_data == r_csum) begin
            w_state_nxt = ST_MEM_REQ;
          end else begin
            w_tx_buf_nxt = {24'h0, C_BADSUM};
            w_tx_len_nxt = 3'd1;
            w_err_evt    = 1'b1;
            w_state_nxt  = ST_SEND;
          end
        end else if (w_tmo_hit) begin
          w_err_evt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
`endif

      ST_MEM_REQ: begin
        w_err_evt = rx_valid;
        if (mem_gnt) begin
          if (r_is_write) begin
            w_tx_buf_nxt = {24'h0, C_ACK};
            w_tx_len_nxt = 3'd1;
            w_state_nxt  = ST_SEND;
          end else begin
            w_state_nxt  = ST_MEM_WAIT;
          end
        end
      end

      ST_MEM_WAIT: begin
        // Read data is valid exactly one cycle after the granted read.
        w_err_evt    = rx_valid;
        w_tx_buf_nxt = mem_rdata;
        w_tx_len_nxt = 3'd4;
        w_state_nxt  = ST_SEND;
      end

      ST_SEND: begin
        w_err_evt = rx_valid;
        if (tx_ready) begin
          w_tx_buf_nxt = {8'h00, r_tx_buf[31:8]};
          w_tx_len_nxt = r_tx_len - 3'd1;
          if (r_tx_len == 3'd1) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Simultaneous error sources count once; the counter sticks at all-ones.
    w_err_nxt = (w_err_evt && !(&r_err)) ? r_err + 1'b1 : r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_sram_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_sram_cmd_ctrl
//  Purpose  : Directed self-checking bench for uart_sram_cmd_ctrl with a
//             small SRAM responder and a TX byte collector.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_sram_cmd_ctrl;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 40;
  localparam int ERR_W   = 8;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic [ERR_W-1:0]  err_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  logic [31:0]       mem [0:255];
  int                wr_cnt = 0;
  int                rd_cnt = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       last_wdata = '0;
  logic [7:0]        txq [$];

  uart_sram_cmd_ctrl #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .ERR_W  (ERR_W)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_gnt  (mem_gnt),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM responder: read data appears one cycle after the granted read.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      last_addr <= mem_addr;
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        last_wdata    <= mem_wdata;
        wr_cnt        <= wr_cnt + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Bytes taken from the low end of 'bytes'; checksum appended when enabled.
  task automatic send_frame(input logic [47:0] bytes, input int n);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      b  = bytes[8*i +: 8];
      cs = cs ^ b;
      send_byte(b);
    end
`ifdef UART_CSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    chk(tag, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    logic stable;
    int   i;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    mem_gnt  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {tx_valid, mem_req, mem_we, busy, tx_data, mem_addr}, 32'h0);
    chk("rst_err", {24'h0, err_cnt}, 32'h0);
    rst = 1'b0;
    tick();

    // 1: write 0xDEADBEEF to 0x05, grant immediate
    send_frame(48'h00_DE_AD_BE_EF_05_57 >> 0, 6);
    chk("t1_req_lat", {31'h0, mem_req}, 32'h1);
    wait_idle("t1_idle", 50);
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_addr", {24'h0, last_addr}, 32'h05);
    chk("t1_wdata", last_wdata, 32'hDEADBEEF);
    chk("t1_txn", txq.size(), 1);
    chk("t1_tx0", {24'h0, txq[0]}, 32'h4B);
    txq.delete();

    // 2: read back 0x05
    send_frame(48'h05_52, 2);
    wait_idle("t2_idle", 50);
    chk("t2_rd_cnt", rd_cnt, 1);
    chk("t2_addr", {24'h0, last_addr}, 32'h05);
    chk("t2_txn", txq.size(), 4);
    chk("t2_txdata", {txq[3], txq[2], txq[1], txq[0]}, 32'hDEADBEEF);
    chk("t2_busy", {31'h0, busy}, 32'h0);
    txq.delete();

    // 3: preload 0x10, then read it with grant withheld for 20 cycles
    send_frame(48'h12_34_56_78_10_57, 6);
    wait_idle("t3_wr_idle", 50);
    txq.delete();
    mem_gnt = 1'b0;
    send_frame(48'h10_52, 2);
    stable = 1'b1;
    for (i = 0; i < 20; i++) begin
      if (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 8'h10)) stable = 1'b0;
      tick();
    end
    chk("t3_req_held", {31'h0, stable}, 32'h1);
    chk("t3_rd_none", rd_cnt, 1);
    mem_gnt = 1'b1;
    wait_idle("t3_idle", 50);
    chk("t3_rd_cnt", rd_cnt, 2);
    chk("t3_txdata", {txq[3], txq[2], txq[1], txq[0]}, 32'h12345678);
    txq.delete();

    // 4: bad opcode, then truncated write left to time out
    send_byte(8'h41);
    wait_idle("t4_bad_idle", 20);
    chk("t4_bad_tx", {txq.size() == 1, 23'h0, txq[0]}, {1'b1, 23'h0, 8'h3F});
    chk("t4_err1", {24'h0, err_cnt}, 32'h1);
    txq.delete();
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (TIMEOUT - 1) tick();
    chk("t4_tmo_busy", {31'h0, busy}, 32'h1);
    tick();
    chk("t4_tmo_idle", {31'h0, busy}, 32'h0);
    chk("t4_err2", {24'h0, err_cnt}, 32'h2);
    chk("t4_tmo_notx", txq.size(), 0);
    chk("t4_tmo_nowr", wr_cnt, 2);

    // 5: back-pressure during read reply; stray byte during SEND counts as error
    tx_ready = 1'b0;
    send_frame(48'h05_52, 2);
    i = 0;
    while (!tx_valid && i < 20) begin
      tick();
      i++;
    end
    chk("t5_txv", {31'h0, tx_valid}, 32'h1);
    send_byte(8'h99);
    stable = 1'b1;
    for (i = 0; i < 50; i++) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'hEF)) stable = 1'b0;
      tick();
    end
    chk("t5_frozen", {31'h0, stable}, 32'h1);
    chk("t5_err3", {24'h0, err_cnt}, 32'h3);
    tx_ready = 1'b1;
    wait_idle("t5_idle", 20);
    chk("t5_txn", txq.size(), 4);
    chk("t5_txdata", {txq[3], txq[2], txq[1], txq[0]}, 32'hDEADBEEF);
    txq.delete();

`ifdef UART_CSUM_EN
    // 6: explicit checksum good and bad
    send_byte(8'h52);
    send_byte(8'h05);
    send_byte(8'h57);
    wait_idle("t6_good_idle", 50);
    chk("t6_good_tx", {txq[3], txq[2], txq[1], txq[0]}, 32'hDEADBEEF);
    txq.delete();
    i = rd_cnt;
    send_byte(8'h52);
    send_byte(8'h05);
    send_byte(8'h00);
    wait_idle("t6_bad_idle", 50);
    chk("t6_bad_tx", {txq.size() == 1, 23'h0, txq[0]}, {1'b1, 23'h0, 8'h21});
    chk("t6_no_rd", rd_cnt, i);
    chk("t6_err4", {24'h0, err_cnt}, 32'h4);
    txq.delete();
`endif

    // Reset asserted in the middle of SEND
    tx_ready = 1'b0;
    send_frame(48'h05_52, 2);
    i = 0;
    while (!tx_valid && i < 20) begin
      tick();
      i++;
    end
    chk("rs_txv", {31'h0, tx_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_outs", {tx_valid, mem_req, busy, tx_data, mem_addr}, 32'h0);
    chk("rs_err", {24'h0, err_cnt}, 32'h0);
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    txq.delete();
    tick();
    send_frame(48'h44_33_22_11_07_57, 6);
    wait_idle("rs_wr_idle", 50);
    chk("rs_wr_addr", {24'h0, last_addr}, 32'h07);
    chk("rs_wdata", last_wdata, 32'h44332211);
    chk("rs_tx", {txq.size() == 1, 23'h0, txq[0]}, {1'b1, 23'h0, 8'h4B});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
